wb_pipe_reg: RTL and testbench
==============================

Name: wb_pipe_reg

Overview:
Parametrised memory-to-writeback pipeline register, generalised to DEPTH stages.
- Per-stage valid bit, with freeze (stall) and flush controls.
- Pre-muxed writeback value output.
- Two-port forwarding lookup across all in-flight stages.
- Sits between the MEM stage and the register file and feeds the hazard/forwarding unit.

Parameters:
DATA_W, 32, width of ALU result, memory read value and writeback value
REG_W, 4, width of destination and source register indices
DEPTH, 1, number of register stages (DEPTH >= 1), so input-to-output latency = DEPTH cycles

Ports:
clk  input  1  rising-edge clock
rst  input  1  reset, asynchronous, active-high
freeze  input  1  hold all stages (stall)
flush  input  1  invalidate all stages
valid_in  input  1  input bundle is a real instruction
wb_en_in  input  1  instruction writes the register file
mem_r_en_in  input  1  instruction is a load
alu_res_in  input  DATA_W  ALU result
mem_r_val_in  input  DATA_W  memory read data
dst_in  input  REG_W  destination register
src1_in  input  REG_W  forwarding lookup source 1
src2_in  input  REG_W  forwarding lookup source 2
valid_out  output  1  last stage valid
wb_en_out  output  1  last-stage wb_en AND valid
mem_r_en_out  output  1  last-stage mem_r_en AND valid
alu_res_out  output  DATA_W  last-stage ALU result
mem_r_val_out  output  DATA_W  last-stage memory data
dst_out  output  REG_W  last-stage destination
wb_val_out  output  DATA_W  mem_r_en_out ? mem_r_val_out : alu_res_out
fwd1_hit  output  1  src1_in matches an in-flight writer
fwd1_val  output  DATA_W  forwarded value for src1 (0 when no hit)
fwd2_hit  output  1  src2_in matches an in-flight writer
fwd2_val  output  DATA_W  forwarded value for src2 (0 when no hit)

Behaviour:
- Storage: stages 0..DEPTH-1. Each stage holds {valid, wb_en, mem_r_en, alu_res, mem_r_val, dst}. Stage 0 captures the inputs; stage k captures stage k-1; stage DEPTH-1 drives the outputs.
- Reset (async, rst=1): every field of every stage is cleared to 0, so all outputs are 0 immediately, without waiting for a clock edge. The block resumes normal shifting on the first posedge after rst deasserts.
- Per posedge, first matching rule applies:
  - flush=1: all valid bits cleared; data fields may keep their values. The input bundle is dropped. Flush overrides freeze.
  - freeze=1: all stages hold every field.
  - otherwise: shift by one stage; stage 0 takes valid_in and the input bundle.
- Gating: wb_en_out and mem_r_en_out are 0 whenever valid_out=0. alu_res_out, mem_r_val_out and dst_out pass raw.
- wb_val_out: combinational from the last stage.
- Forwarding lookup (combinational):
  - Stage k is a candidate when valid[k] & wb_en[k] & (dst[k]==srcN_in).
  - Hit = OR over all candidates.
  - On multiple candidates, the lowest index (youngest instruction) wins. Its value is mem_r_en[k] ? mem_r_val[k] : alu_res[k].
  - fwdN_val = 0 when there is no hit.
- Freeze does not affect the lookup; it reflects the currently held contents.
- DEPTH=1 behaves as a plain writeback register with freeze, flush, valid and forwarding added.

Test Plan:
- DEPTH=1, reset, then valid_in=1, wb_en_in=1, mem_r_en_in=0, alu_res_in=0x12345678, dst_in=5 -> after 1 edge: wb_en_out=1, dst_out=5, wb_val_out=0x12345678; assert rst mid-cycle -> all outputs 0 before the next edge.
- DEPTH=3, inject 3 loads with mem_r_val 0xA, 0xB, 0xC on consecutive cycles -> wb_val_out shows 0xA, 0xB, 0xC on cycles 3, 4, 5; mem_r_en_out=1 on those cycles.
- DEPTH=3, freeze high for 2 cycles mid-stream -> outputs and lookups constant for 2 cycles; sequence resumes with no bundle lost or duplicated.
- flush and freeze both high with valid_in=1 -> next cycle all valid=0, wb_en_out=0, fwd hits 0; the input bundle never appears at the output.
- DEPTH=3, stage 0 holds dst=2 (alu 0x11) and stage 2 holds dst=2 (alu 0x22), src1_in=2 -> fwd1_hit=1, fwd1_val=0x11; clear stage 0 wb_en -> fwd1_val=0x22.
- src2_in matches a stage with valid=0 or wb_en=0 -> fwd2_hit=0, fwd2_val=0.

Source files
------------

// File: rtl/wb_pipe_reg.sv
// rtl/wb_pipe_reg.sv - DEPTH-stage MEM-to-writeback pipeline register with flush, freeze and forwarding lookup
module wb_pipe_reg #(
   parameter int DATA_W = 32,
   parameter int REG_W  = 4,
   parameter int DEPTH  = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              freeze,
   input  logic              flush,
   input  logic              valid_in,
   input  logic              wb_en_in,
   input  logic              mem_r_en_in,
   input  logic [DATA_W-1:0] alu_res_in,
   input  logic [DATA_W-1:0] mem_r_val_in,
   input  logic [REG_W-1:0]  dst_in,
   input  logic [REG_W-1:0]  src1_in,
   input  logic [REG_W-1:0]  src2_in,
   output logic              valid_out,
   output logic              wb_en_out,
   output logic              mem_r_en_out,
   output logic [DATA_W-1:0] alu_res_out,
   output logic [DATA_W-1:0] mem_r_val_out,
   output logic [REG_W-1:0]  dst_out,
   output logic [DATA_W-1:0] wb_val_out,
   output logic              fwd1_hit,
   output logic [DATA_W-1:0] fwd1_val,
   output logic              fwd2_hit,
   output logic [DATA_W-1:0] fwd2_val
);

   localparam int LAST = DEPTH - 1;

   // Stage 0 is the youngest instruction, stage LAST drives the outputs.
   logic              valid_q     [DEPTH];
   logic              valid_d     [DEPTH];
   logic              wb_en_q     [DEPTH];
   logic              wb_en_d     [DEPTH];
   logic              mem_r_en_q  [DEPTH];
   logic              mem_r_en_d  [DEPTH];
   logic [DATA_W-1:0] alu_res_q   [DEPTH];
   logic [DATA_W-1:0] alu_res_d   [DEPTH];
   logic [DATA_W-1:0] mem_r_val_q [DEPTH];
   logic [DATA_W-1:0] mem_r_val_d [DEPTH];
   logic [REG_W-1:0]  dst_q       [DEPTH];
   logic [REG_W-1:0]  dst_d       [DEPTH];

   // Value each stage would write back, shared by the output mux and the lookup.
   logic [DATA_W-1:0] stage_wb_val [DEPTH];

   // Next-state: flush kills valid bits only (data may linger), freeze holds, else shift.
   always_comb begin
      for (int k = 0; k < DEPTH; k++) begin
         valid_d[k]     = valid_q[k];
         wb_en_d[k]     = wb_en_q[k];
         mem_r_en_d[k]  = mem_r_en_q[k];
         alu_res_d[k]   = alu_res_q[k];
         mem_r_val_d[k] = mem_r_val_q[k];
         dst_d[k]       = dst_q[k];
      end
      if (flush) begin
         for (int k = 0; k < DEPTH; k++) begin
            valid_d[k] = 1'b0;
         end
      end else if (!freeze) begin
         valid_d[0]     = valid_in;
         wb_en_d[0]     = wb_en_in;
         mem_r_en_d[0]  = mem_r_en_in;
         alu_res_d[0]   = alu_res_in;
         mem_r_val_d[0] = mem_r_val_in;
         dst_d[0]       = dst_in;
         for (int k = 1; k < DEPTH; k++) begin
            valid_d[k]     = valid_q[k-1];
            wb_en_d[k]     = wb_en_q[k-1];
            mem_r_en_d[k]  = mem_r_en_q[k-1];
            alu_res_d[k]   = alu_res_q[k-1];
            mem_r_val_d[k] = mem_r_val_q[k-1];
            dst_d[k]       = dst_q[k-1];
         end
      end
   end

   // Stage registers; reset clears every field so outputs drop to zero at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < DEPTH; k++) begin
            valid_q[k]     <= 1'b0;
            wb_en_q[k]     <= 1'b0;
            mem_r_en_q[k]  <= 1'b0;
            alu_res_q[k]   <= '0;
            mem_r_val_q[k] <= '0;
            dst_q[k]       <= '0;
         end
      end else begin
         for (int k = 0; k < DEPTH; k++) begin
            valid_q[k]     <= valid_d[k];
            wb_en_q[k]     <= wb_en_d[k];
            mem_r_en_q[k]  <= mem_r_en_d[k];
            alu_res_q[k]   <= alu_res_d[k];
            mem_r_val_q[k] <= mem_r_val_d[k];
            dst_q[k]       <= dst_d[k];
         end
      end
   end

   // Per-stage writeback value: load data for loads, ALU result otherwise.
   always_comb begin
      for (int k = 0; k < DEPTH; k++) begin
         stage_wb_val[k] = mem_r_en_q[k] ? mem_r_val_q[k] : alu_res_q[k];
      end
   end

   assign valid_out     = valid_q[LAST];
   assign wb_en_out     = wb_en_q[LAST] & valid_q[LAST];
   assign mem_r_en_out  = mem_r_en_q[LAST] & valid_q[LAST];
   assign alu_res_out   = alu_res_q[LAST];
   assign mem_r_val_out = mem_r_val_q[LAST];
   assign dst_out       = dst_q[LAST];
   assign wb_val_out    = mem_r_en_out ? mem_r_val_out : alu_res_out;

   // Forwarding lookup: scan oldest to youngest so the youngest matching writer wins.
   always_comb begin
      fwd1_hit = 1'b0;
      fwd1_val = '0;
      fwd2_hit = 1'b0;
      fwd2_val = '0;
      for (int k = LAST; k >= 0; k--) begin
         if (valid_q[k] && wb_en_q[k] && (dst_q[k] == src1_in)) begin
            fwd1_hit = 1'b1;
            fwd1_val = stage_wb_val[k];
         end
         if (valid_q[k] && wb_en_q[k] && (dst_q[k] == src2_in)) begin
            fwd2_hit = 1'b1;
            fwd2_val = stage_wb_val[k];
         end
      end
   end

endmodule

// File: tb/tb_wb_pipe_reg.sv
// tb/tb_wb_pipe_reg.sv - scoreboard bench for wb_pipe_reg at DEPTH=1 and DEPTH=3
module tb_wb_pipe_reg;

   typedef struct {
      logic [31:0] wb_val;
      logic [3:0]  dst;
      logic        wb_en;
      logic        mem_r_en;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        freeze = 1'b0;
   logic        flush = 1'b0;
   logic        valid_in = 1'b0;
   logic        wb_en_in = 1'b0;
   logic        mem_r_en_in = 1'b0;
   logic [31:0] alu_res_in = '0;
   logic [31:0] mem_r_val_in = '0;
   logic [3:0]  dst_in = '0;
   logic [3:0]  src1_in = '0;
   logic [3:0]  src2_in = '0;

   logic        o1_valid, o1_wb_en, o1_mem_r_en, o1_fwd1_hit, o1_fwd2_hit;
   logic [31:0] o1_alu, o1_mem, o1_wb_val, o1_fwd1_val, o1_fwd2_val;
   logic [3:0]  o1_dst;
   logic        o3_valid, o3_wb_en, o3_mem_r_en, o3_fwd1_hit, o3_fwd2_hit;
   logic [31:0] o3_alu, o3_mem, o3_wb_val, o3_fwd1_val, o3_fwd2_val;
   logic [3:0]  o3_dst;

   int   checks = 0;
   int   errors = 0;
   exp_t q1[$];
   exp_t q3[$];

   wb_pipe_reg #(.DATA_W(32), .REG_W(4), .DEPTH(1)) dut1 (
      .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
      .valid_in(valid_in), .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in),
      .alu_res_in(alu_res_in), .mem_r_val_in(mem_r_val_in), .dst_in(dst_in),
      .src1_in(src1_in), .src2_in(src2_in),
      .valid_out(o1_valid), .wb_en_out(o1_wb_en), .mem_r_en_out(o1_mem_r_en),
      .alu_res_out(o1_alu), .mem_r_val_out(o1_mem), .dst_out(o1_dst),
      .wb_val_out(o1_wb_val), .fwd1_hit(o1_fwd1_hit), .fwd1_val(o1_fwd1_val),
      .fwd2_hit(o1_fwd2_hit), .fwd2_val(o1_fwd2_val)
   );

   wb_pipe_reg #(.DATA_W(32), .REG_W(4), .DEPTH(3)) dut3 (
      .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
      .valid_in(valid_in), .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in),
      .alu_res_in(alu_res_in), .mem_r_val_in(mem_r_val_in), .dst_in(dst_in),
      .src1_in(src1_in), .src2_in(src2_in),
      .valid_out(o3_valid), .wb_en_out(o3_wb_en), .mem_r_en_out(o3_mem_r_en),
      .alu_res_out(o3_alu), .mem_r_val_out(o3_mem), .dst_out(o3_dst),
      .wb_val_out(o3_wb_val), .fwd1_hit(o3_fwd1_hit), .fwd1_val(o3_fwd1_val),
      .fwd2_hit(o3_fwd2_hit), .fwd2_val(o3_fwd2_val)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   // Hard time limit so the run can never hang.
   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_in(input logic v, input logic we, input logic me,
                         input logic [31:0] alu, input logic [31:0] mem, input logic [3:0] d);
      valid_in = v; wb_en_in = we; mem_r_en_in = me;
      alu_res_in = alu; mem_r_val_in = mem; dst_in = d;
   endtask

   task automatic sb_check(input int which, input logic v, input logic we, input logic me,
                           input logic [31:0] wv, input logic [3:0] d);
      exp_t e;
      int   qs;
      if (!v) begin
         chk($sformatf("d%0d_gate_wb_en", which), {31'b0, we}, 32'd0);
         chk($sformatf("d%0d_gate_mem_r_en", which), {31'b0, me}, 32'd0);
         return;
      end
      qs = (which == 1) ? q1.size() : q3.size();
      chk($sformatf("d%0d_sb_nonempty", which), {31'b0, (qs > 0)}, 32'd1);
      if (qs == 0) return;
      e = (which == 1) ? q1.pop_front() : q3.pop_front();
      chk($sformatf("d%0d_sb_wb_val", which), wv, e.wb_val);
      chk($sformatf("d%0d_sb_dst", which), {28'b0, d}, {28'b0, e.dst});
      chk($sformatf("d%0d_sb_wb_en", which), {31'b0, we}, {31'b0, e.wb_en});
      chk($sformatf("d%0d_sb_mem_r_en", which), {31'b0, me}, {31'b0, e.mem_r_en});
   endtask

   // One clock: update the scoreboard for the edge, then check outputs 1 time unit later.
   task automatic tick();
      logic        frz;
      logic [31:0] s_wb3, s_f13, s_f23, s_wb1;
      logic        s_v3, s_h13, s_h23, s_v1;
      logic [3:0]  s_d3;
      exp_t        e;
      frz   = freeze && !flush;
      s_wb3 = o3_wb_val; s_f13 = o3_fwd1_val; s_f23 = o3_fwd2_val; s_d3 = o3_dst;
      s_v3  = o3_valid;  s_h13 = o3_fwd1_hit; s_h23 = o3_fwd2_hit;
      s_wb1 = o1_wb_val; s_v1 = o1_valid;
      if (flush) begin
         q1.delete();
         q3.delete();
      end else if (!freeze && valid_in) begin
         e.wb_val   = mem_r_en_in ? mem_r_val_in : alu_res_in;
         e.dst      = dst_in;
         e.wb_en    = wb_en_in;
         e.mem_r_en = mem_r_en_in;
         q1.push_back(e);
         q3.push_back(e);
      end
      @(posedge clk);
      #1;
      if (frz) begin
         chk("frz_d3_valid", {31'b0, o3_valid}, {31'b0, s_v3});
         chk("frz_d3_wb_val", o3_wb_val, s_wb3);
         chk("frz_d3_dst", {28'b0, o3_dst}, {28'b0, s_d3});
         chk("frz_d3_fwd1_hit", {31'b0, o3_fwd1_hit}, {31'b0, s_h13});
         chk("frz_d3_fwd1_val", o3_fwd1_val, s_f13);
         chk("frz_d3_fwd2_hit", {31'b0, o3_fwd2_hit}, {31'b0, s_h23});
         chk("frz_d3_fwd2_val", o3_fwd2_val, s_f23);
         chk("frz_d1_valid", {31'b0, o1_valid}, {31'b0, s_v1});
         chk("frz_d1_wb_val", o1_wb_val, s_wb1);
      end else begin
         sb_check(1, o1_valid, o1_wb_en, o1_mem_r_en, o1_wb_val, o1_dst);
         sb_check(3, o3_valid, o3_wb_en, o3_mem_r_en, o3_wb_val, o3_dst);
      end
   endtask

   // Directed sequence.
   initial begin
      // Reset state
      #2;
      chk("rst_d1_valid", {31'b0, o1_valid}, 32'd0);
      chk("rst_d1_wb_val", o1_wb_val, 32'd0);
      chk("rst_d3_valid", {31'b0, o3_valid}, 32'd0);
      chk("rst_d3_wb_en", {31'b0, o3_wb_en}, 32'd0);
      chk("rst_d3_dst", {28'b0, o3_dst}, 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;

      // DEPTH=1 basic writeback, then async reset mid-cycle
      src1_in = 4'd5;
      set_in(1'b1, 1'b1, 1'b0, 32'h1234_5678, 32'h0, 4'd5);
      tick();
      chk("d1_wb_en", {31'b0, o1_wb_en}, 32'd1);
      chk("d1_dst", {28'b0, o1_dst}, 32'd5);
      chk("d1_wb_val", o1_wb_val, 32'h1234_5678);
      chk("d3_fwd1_pre_rst", {31'b0, o3_fwd1_hit}, 32'd1);
      set_in(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
      #3 rst = 1'b1;
      #1;
      chk("arst_d1_valid", {31'b0, o1_valid}, 32'd0);
      chk("arst_d1_wb_en", {31'b0, o1_wb_en}, 32'd0);
      chk("arst_d1_dst", {28'b0, o1_dst}, 32'd0);
      chk("arst_d1_wb_val", o1_wb_val, 32'd0);
      chk("arst_d1_alu", o1_alu, 32'd0);
      chk("arst_d3_fwd1_hit", {31'b0, o3_fwd1_hit}, 32'd0);
      chk("arst_d3_fwd1_val", o3_fwd1_val, 32'd0);
      q1.delete();
      q3.delete();
      @(posedge clk);
      #1 rst = 1'b0;

      // DEPTH=3: three back-to-back loads, output on edges 3..5
      src1_in = 4'd1;
      src2_in = 4'd3;
      set_in(1'b1, 1'b1, 1'b1, 32'hDEAD, 32'hA, 4'd1);
      tick();
      chk("ld_e1_d3_valid", {31'b0, o3_valid}, 32'd0);
      set_in(1'b1, 1'b1, 1'b1, 32'hDEAD, 32'hB, 4'd2);
      tick();
      chk("ld_e2_d3_valid", {31'b0, o3_valid}, 32'd0);
      set_in(1'b1, 1'b1, 1'b1, 32'hDEAD, 32'hC, 4'd3);
      tick();
      chk("ld_e3_wb_val", o3_wb_val, 32'hA);
      chk("ld_e3_mem_r_en", {31'b0, o3_mem_r_en}, 32'd1);
      chk("ld_fwd1_val", o3_fwd1_val, 32'hA);
      chk("ld_fwd2_val", o3_fwd2_val, 32'hC);
      set_in(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
      tick();
      chk("ld_e4_wb_val", o3_wb_val, 32'hB);
      chk("ld_e4_mem_r_en", {31'b0, o3_mem_r_en}, 32'd1);
      tick();
      chk("ld_e5_wb_val", o3_wb_val, 32'hC);
      chk("ld_e5_mem_r_en", {31'b0, o3_mem_r_en}, 32'd1);
      tick();
      chk("ld_e6_valid", {31'b0, o3_valid}, 32'd0);

      // Freeze for two cycles mid-stream
      src1_in = 4'd5;
      src2_in = 4'd6;
      set_in(1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 4'd4);
      tick();
      set_in(1'b1, 1'b1, 1'b0, 32'h101, 32'h0, 4'd5);
      tick();
      set_in(1'b1, 1'b1, 1'b0, 32'h102, 32'h0, 4'd6);
      tick();
      chk("frz_pre_fwd1", o3_fwd1_val, 32'h101);
      freeze = 1'b1;
      set_in(1'b1, 1'b1, 1'b0, 32'h103, 32'h0, 4'd7);
      tick();
      tick();
      chk("frz_out_held", o3_wb_val, 32'h100);
      freeze = 1'b0;
      tick();
      chk("frz_resume", o3_wb_val, 32'h101);
      set_in(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
      tick();
      tick();
      chk("frz_last", o3_wb_val, 32'h103);
      tick();

      // Flush overrides freeze and drops the incoming bundle
      set_in(1'b1, 1'b1, 1'b0, 32'h200, 32'h0, 4'd8);
      tick();
      flush = 1'b1;
      freeze = 1'b1;
      src1_in = 4'd8;
      src2_in = 4'd9;
      set_in(1'b1, 1'b1, 1'b0, 32'h2FF, 32'h0, 4'd9);
      tick();
      chk("fl_d3_valid", {31'b0, o3_valid}, 32'd0);
      chk("fl_d3_wb_en", {31'b0, o3_wb_en}, 32'd0);
      chk("fl_d3_fwd1_hit", {31'b0, o3_fwd1_hit}, 32'd0);
      chk("fl_d3_fwd2_hit", {31'b0, o3_fwd2_hit}, 32'd0);
      chk("fl_d1_valid", {31'b0, o1_valid}, 32'd0);
      chk("fl_d1_fwd2_val", o1_fwd2_val, 32'd0);
      flush = 1'b0;
      freeze = 1'b0;
      set_in(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("fl_drain%0d_valid", i), {31'b0, o3_valid}, 32'd0);
      end

      // Forwarding priority: youngest writer wins
      src1_in = 4'd2;
      src2_in = 4'd7;
      set_in(1'b1, 1'b1, 1'b0, 32'h22, 32'h0, 4'd2);
      tick();
      set_in(1'b1, 1'b1, 1'b0, 32'h33, 32'h0, 4'd7);
      tick();
      set_in(1'b1, 1'b1, 1'b0, 32'h11, 32'h0, 4'd2);
      tick();
      chk("fw_d3_hit", {31'b0, o3_fwd1_hit}, 32'd1);
      chk("fw_d3_val", o3_fwd1_val, 32'h11);
      chk("fw_d3_f2_val", o3_fwd2_val, 32'h33);
      chk("fw_d1_val", o1_fwd1_val, 32'h11);
      set_in(1'b1, 1'b1, 1'b0, 32'h22, 32'h0, 4'd2);
      tick();
      set_in(1'b1, 1'b0, 1'b0, 32'h33, 32'h0, 4'd7);
      tick();
      set_in(1'b1, 1'b0, 1'b0, 32'h11, 32'h0, 4'd2);
      tick();
      chk("fw2_d3_hit", {31'b0, o3_fwd1_hit}, 32'd1);
      chk("fw2_d3_val", o3_fwd1_val, 32'h22);
      chk("fw2_d3_f2_hit", {31'b0, o3_fwd2_hit}, 32'd0);
      chk("fw2_d3_f2_val", o3_fwd2_val, 32'd0);
      chk("fw2_d1_hit", {31'b0, o1_fwd1_hit}, 32'd0);
      chk("fw2_d1_val", o1_fwd1_val, 32'd0);
      set_in(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
      for (int i = 0; i < 4; i++) tick();
      chk("end_q1_empty", q1.size(), 32'd0);
      chk("end_q3_empty", q3.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
